// File: rtl/prog_mem_controller.sv
// prog_mem_controller
// Round-robin arbiter that serialises per-core instruction fetch requests
// onto a single program-memory read channel and relays each fetched word
// back to the requesting fetcher with a registered ready/data pair.
module prog_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data
);

  // A single consumer still needs a one-bit index so the pointer is never zero width.
  localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] RELAY    = 2'd2;

  localparam logic [IDX_BITS-1:0] LAST_INIT = IDX_BITS'(NUM_CONSUMERS - 1);

  logic [1:0]          state_r;
  logic [IDX_BITS-1:0] last_r;     // most recently served consumer (lowest priority)
  logic [IDX_BITS-1:0] winner_r;   // consumer currently in service
  logic                grant_found_s;
  logic [IDX_BITS-1:0] grant_idx_s;
  int                  cand_s;

  // Round-robin search starting just after the last served consumer.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IDX_BITS{1'b0}};
    cand_s        = 0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      cand_s = (int'(last_r) + k) % NUM_CONSUMERS;
      if (!grant_found_s && consumer_read_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[IDX_BITS-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Request/response sequencing and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r             <= IDLE;
      last_r              <= LAST_INIT;
      winner_r            <= {IDX_BITS{1'b0}};
      mem_read_valid      <= 1'b0;
      mem_read_address    <= {ADDR_BITS{1'b0}};
      consumer_read_ready <= {NUM_CONSUMERS{1'b0}};
      consumer_read_data  <= {(NUM_CONSUMERS*DATA_BITS){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            winner_r         <= grant_idx_s;
            mem_read_address <= consumer_read_address[int'(grant_idx_s)*ADDR_BITS +: ADDR_BITS];
            mem_read_valid   <= 1'b1;
            state_r          <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // Memory may stall indefinitely; the request is simply held.
          if (mem_read_ready) begin
            mem_read_valid                                          <= 1'b0;
            consumer_read_data[int'(winner_r)*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[winner_r]                           <= 1'b1;
            state_r                                                 <= RELAY;
          end
        end
        RELAY: begin
          // A fetcher that already dropped valid still gets a one-cycle pulse.
          if (!consumer_read_valid[winner_r]) begin
            consumer_read_ready <= {NUM_CONSUMERS{1'b0}};
            last_r              <= winner_r;
            state_r             <= IDLE;
          end
        end
        default: begin
          state_r             <= IDLE;
          mem_read_valid      <= 1'b0;
          consumer_read_ready <= {NUM_CONSUMERS{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_controller.sv
// Directed testbench for prog_mem_controller (4 consumers, 8-bit address, 16-bit data).
module tb_prog_mem_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  consumer_read_valid = 4'b0000;
  logic [31:0] consumer_read_address = 32'h0;
  logic [3:0]  consumer_read_ready;
  logic [63:0] consumer_read_data;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'h0;

  int checks = 0;
  int errors = 0;

  prog_mem_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (consumer_read_valid),
    .consumer_read_address (consumer_read_address),
    .consumer_read_ready   (consumer_read_ready),
    .consumer_read_data    (consumer_read_data),
    .mem_read_valid        (mem_read_valid),
    .mem_read_address      (mem_read_address),
    .mem_read_ready        (mem_read_ready),
    .mem_read_data         (mem_read_data)
  );

  always #5 clk = ~clk;

  // Advance one active edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    consumer_read_valid = 4'b0000;
    apply_reset();
    checks++;
    if (mem_read_valid !== 1'b0 || mem_read_address !== 8'h00) begin
      errors++; $display("FAIL reset_mem: got valid=%b addr=%h expected 0/00", mem_read_valid, mem_read_address);
    end
    checks++;
    if (consumer_read_ready !== 4'b0000 || consumer_read_data !== 64'h0) begin
      errors++; $display("FAIL reset_consumer: got ready=%b data=%h expected 0", consumer_read_ready, consumer_read_data);
    end
  endtask

  task automatic test_single();
    consumer_read_address[2*8 +: 8] = 8'h1A;
    consumer_read_valid = 4'b0100;
    tick();
    checks++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h1A) begin
      errors++; $display("FAIL single_req: got valid=%b addr=%h expected 1/1a", mem_read_valid, mem_read_address);
    end
    mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    tick();
    mem_read_ready = 1'b0;
    checks++;
    if (consumer_read_ready !== 4'b0100 || consumer_read_data[2*16 +: 16] !== 16'hBEEF || mem_read_valid !== 1'b0) begin
      errors++; $display("FAIL single_resp: got ready=%b data2=%h mvalid=%b expected 0100/beef/0",
                         consumer_read_ready, consumer_read_data[2*16 +: 16], mem_read_valid);
    end
    tick();
    checks++;
    if (consumer_read_ready !== 4'b0100) begin
      errors++; $display("FAIL single_hold: got ready=%b expected 0100", consumer_read_ready);
    end
    consumer_read_valid = 4'b0000;
    tick();
    checks++;
    if (consumer_read_ready !== 4'b0000) begin
      errors++; $display("FAIL single_drop: got ready=%b expected 0000", consumer_read_ready);
    end
    tick();
    checks++;
    if (mem_read_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: got mvalid=%b expected 0", mem_read_valid);
    end
  endtask

  task automatic test_round_robin();
    consumer_read_address[1*8 +: 8] = 8'h41;
    consumer_read_address[3*8 +: 8] = 8'h43;
    consumer_read_valid = 4'b1010;
    tick();
    checks++;
    if (mem_read_address !== 8'h43 || mem_read_valid !== 1'b1) begin
      errors++; $display("FAIL rr_first: got addr=%h valid=%b expected 43/1", mem_read_address, mem_read_valid);
    end
    mem_read_ready = 1'b1; mem_read_data = 16'h3333;
    tick();
    mem_read_ready = 1'b0;
    checks++;
    if (consumer_read_ready !== 4'b1000 || consumer_read_data[3*16 +: 16] !== 16'h3333) begin
      errors++; $display("FAIL rr_resp3: got ready=%b data3=%h expected 1000/3333", consumer_read_ready, consumer_read_data[3*16 +: 16]);
    end
    consumer_read_valid = 4'b0010;
    tick();
    tick();
    checks++;
    if (mem_read_address !== 8'h41 || mem_read_valid !== 1'b1) begin
      errors++; $display("FAIL rr_second: got addr=%h valid=%b expected 41/1", mem_read_address, mem_read_valid);
    end
    mem_read_ready = 1'b1; mem_read_data = 16'h1111;
    tick();
    mem_read_ready = 1'b0;
    checks++;
    if (consumer_read_ready !== 4'b0010 || consumer_read_data[1*16 +: 16] !== 16'h1111
        || consumer_read_data[3*16 +: 16] !== 16'h3333 || consumer_read_data[2*16 +: 16] !== 16'hBEEF) begin
      errors++; $display("FAIL rr_resp1: got ready=%b data=%h expected 0010 with 3333_beef_1111_xxxx", consumer_read_ready, consumer_read_data);
    end
    consumer_read_valid = 4'b0000;
    tick();
  endtask

  task automatic test_simultaneous();
    logic [15:0] word;
    apply_reset();
    for (int i = 0; i < 4; i++) consumer_read_address[i*8 +: 8] = 8'(i * 8'h11);
    consumer_read_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (mem_read_valid !== 1'b1 || mem_read_address !== 8'(i * 8'h11)) begin
        errors++; $display("FAIL sim_addr%0d: got valid=%b addr=%h expected 1/%h", i, mem_read_valid, mem_read_address, 8'(i * 8'h11));
      end
      word = 16'hA000 | 16'(i * 16'h111);
      mem_read_ready = 1'b1; mem_read_data = word;
      tick();
      mem_read_ready = 1'b0;
      checks++;
      if (consumer_read_ready !== (4'b0001 << i) || consumer_read_data[i*16 +: 16] !== word) begin
        errors++; $display("FAIL sim_resp%0d: got ready=%b data=%h expected %b/%h", i, consumer_read_ready,
                           consumer_read_data[i*16 +: 16], 4'b0001 << i, word);
      end
      consumer_read_valid[i] = 1'b0;
      tick();
    end
    checks++;
    if (consumer_read_data !== 64'hA333_A222_A111_A000) begin
      errors++; $display("FAIL sim_all_data: got %h expected a333a222a111a000", consumer_read_data);
    end
  endtask

  task automatic test_stall();
    mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
    tick();
    mem_read_ready = 1'b0;
    checks++;
    if (consumer_read_ready !== 4'b0000 || consumer_read_data[15:0] !== 16'hA000) begin
      errors++; $display("FAIL stray_mem_ready: got ready=%b data0=%h expected 0000/a000", consumer_read_ready, consumer_read_data[15:0]);
    end
    consumer_read_address[7:0] = 8'h55;
    consumer_read_valid = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h55 || consumer_read_ready !== 4'b0000) begin
        errors++; $display("FAIL stall_c%0d: got valid=%b addr=%h ready=%b expected 1/55/0000", c,
                           mem_read_valid, mem_read_address, consumer_read_ready);
      end
    end
    mem_read_ready = 1'b1; mem_read_data = 16'hA5A5;
    tick();
    mem_read_ready = 1'b0;
    checks++;
    if (consumer_read_ready !== 4'b0001 || consumer_read_data[15:0] !== 16'hA5A5) begin
      errors++; $display("FAIL stall_resp: got ready=%b data0=%h expected 0001/a5a5", consumer_read_ready, consumer_read_data[15:0]);
    end
    consumer_read_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    consumer_read_address[3*8 +: 8] = 8'h77;
    consumer_read_valid = 4'b1000;
    tick();
    checks++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h77) begin
      errors++; $display("FAIL rst_pre: got valid=%b addr=%h expected 1/77", mem_read_valid, mem_read_address);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_read_valid !== 1'b0 || mem_read_address !== 8'h00 || consumer_read_ready !== 4'b0000 || consumer_read_data !== 64'h0) begin
      errors++; $display("FAIL rst_async: got valid=%b addr=%h ready=%b data=%h expected all 0",
                         mem_read_valid, mem_read_address, consumer_read_ready, consumer_read_data);
    end
    #1;
    reset = 1'b0;
    consumer_read_address[7:0] = 8'h10;
    consumer_read_address[2*8 +: 8] = 8'h12;
    consumer_read_valid = 4'b1101;
    tick();
    checks++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h10) begin
      errors++; $display("FAIL rst_priority: got valid=%b addr=%h expected 1/10", mem_read_valid, mem_read_address);
    end
    mem_read_ready = 1'b1; mem_read_data = 16'h0F0F;
    tick();
    mem_read_ready = 1'b0;
    consumer_read_valid = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_early_drop();
    consumer_read_address[1*8 +: 8] = 8'h2C;
    consumer_read_valid = 4'b0010;
    tick();
    consumer_read_valid = 4'b0000;
    tick();
    checks++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h2C) begin
      errors++; $display("FAIL drop_wait: got valid=%b addr=%h expected 1/2c", mem_read_valid, mem_read_address);
    end
    mem_read_ready = 1'b1; mem_read_data = 16'h5A5A;
    tick();
    mem_read_ready = 1'b0;
    checks++;
    if (consumer_read_ready !== 4'b0010 || mem_read_valid !== 1'b0) begin
      errors++; $display("FAIL drop_pulse: got ready=%b mvalid=%b expected 0010/0", consumer_read_ready, mem_read_valid);
    end
    consumer_read_address[2*8 +: 8] = 8'h3D;
    consumer_read_valid = 4'b0100;
    tick();
    checks++;
    if (consumer_read_ready !== 4'b0000) begin
      errors++; $display("FAIL drop_end: got ready=%b expected 0000", consumer_read_ready);
    end
    tick();
    checks++;
    if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h3D) begin
      errors++; $display("FAIL drop_idle: got valid=%b addr=%h expected 1/3d", mem_read_valid, mem_read_address);
    end
    consumer_read_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_simultaneous();
    test_stall();
    test_reset_mid_wait();
    test_early_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
